// File: rtl/gamma_pkg.sv
// ---------------------------------------------------------------------------
// gamma_pkg
// Shared constants and types for the gamma fade scheduler.
//   N_CH_DEF / G_PW_DEF / G_OW_DEF / RATE_W_DEF : default parameter values
//   CH_W          : width of a channel index (covers up to 4 channels)
//   sched_state_e : lookup scheduler states
// ---------------------------------------------------------------------------
package gamma_pkg;

  localparam int N_CH_DEF   = 3;
  localparam int G_PW_DEF   = 8;
  localparam int G_OW_DEF   = 16;
  localparam int RATE_W_DEF = 18;
  localparam int CH_W       = 2;

  // S_IDLE: look for a pending channel and issue its ROM address
  // S_WAIT: ROM is reading the address
  // S_CAPT: ROM data is valid, copy it into the channel's shadow compare
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/gamma_rr_arbiter.sv
// ---------------------------------------------------------------------------
// gamma_rr_arbiter
// Combinational round-robin pick over a request vector.
//   req       in  N_CH  request (pending) vector
//   ptr       in  CH_W  first index to consider; must be < N_CH
//   gnt       out CH_W  first requesting index at or after ptr (wrapping)
//   gnt_valid out 1     at least one request is set
// ---------------------------------------------------------------------------
module gamma_rr_arbiter #(
  parameter int N_CH = 3,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt,
  output logic            gnt_valid
);

  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      // (ptr + i) mod N_CH without a divider: ptr < N_CH and i < N_CH,
      // so one conditional subtract is enough.
      sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(N_CH)) begin
        sum = sum - (CH_W+1)'(N_CH);
      end
      idx = sum[CH_W-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt       = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gamma_fade_sched.sv
// ---------------------------------------------------------------------------
// gamma_fade_sched
// Per-channel brightness fader, time-shared gamma ROM lookup and glitch-free
// PWM generation.
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_*        command channel: set target level and step rate of cmd_ch
//   lut_addr     registered address to the external synchronous gamma ROM
//   lut_data     ROM data, valid one clock after lut_addr changes
//   at_target    per channel: level equals target
//   pwm_out      registered active-high PWM per channel
//   sched_state  lookup scheduler state, for observation
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is low in reset and high from the first
// clock after release; the source holds cmd_ch/target/rate stable while
// cmd_valid is high and not yet accepted. Back-to-back transfers are legal.
// ---------------------------------------------------------------------------
module gamma_fade_sched
  import gamma_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int G_PW   = G_PW_DEF,
  parameter int G_OW   = G_OW_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ch,
  input  logic [G_PW-1:0]   cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic [G_PW-1:0]   lut_addr,
  input  logic [G_OW-1:0]   lut_data,
  output logic [N_CH-1:0]   at_target,
  output logic [N_CH-1:0]   pwm_out,
  output sched_state_e      sched_state
);

  // ---- fade engine state ----
  logic [G_PW-1:0]   level_q  [N_CH];
  logic [G_PW-1:0]   target_q [N_CH];
  logic [RATE_W-1:0] rate_q   [N_CH];
  logic [RATE_W-1:0] tick_q   [N_CH];
  logic [G_PW-1:0]   level_d  [N_CH];
  logic [G_PW-1:0]   target_d [N_CH];
  logic [RATE_W-1:0] rate_d   [N_CH];
  logic [RATE_W-1:0] tick_d   [N_CH];
  logic [N_CH-1:0]   lvl_chg;
  logic [N_CH-1:0]   at_target_d;
  logic [N_CH-1:0]   pending_q;
  logic [N_CH-1:0]   pending_d;
  logic [N_CH-1:0]   pend_clr;
  logic              cmd_fire;

  // ---- scheduler state ----
  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic [CH_W-1:0]   gnt;
  logic              gnt_valid;
  logic              issue;
  logic              capture;

  // ---- PWM state ----
  logic [G_OW-1:0]   shadow_q [N_CH];
  logic [G_OW-1:0]   active_q [N_CH];
  logic [G_OW-1:0]   pwm_cnt_q;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign sched_state = state_q;

  // ------------------------------------------------------------------------
  // Fade engine. A command to a channel wins over any step due that cycle.
  // ------------------------------------------------------------------------
  always_comb begin
    lvl_chg     = '0;
    at_target_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      level_d[i]  = level_q[i];
      target_d[i] = target_q[i];
      rate_d[i]   = rate_q[i];
      tick_d[i]   = tick_q[i];
      if (cmd_fire && (cmd_ch == CH_W'(i))) begin
        target_d[i] = cmd_target;
        rate_d[i]   = cmd_rate;
        tick_d[i]   = '0;
      end else if (level_q[i] != target_q[i]) begin
        if (rate_q[i] == '0) begin
          level_d[i] = target_q[i];
        end else if (tick_q[i] == rate_q[i] - RATE_W'(1)) begin
          tick_d[i]  = '0;
          level_d[i] = (target_q[i] > level_q[i]) ? level_q[i] + G_PW'(1)
                                                  : level_q[i] - G_PW'(1);
        end else begin
          tick_d[i] = tick_q[i] + RATE_W'(1);
        end
      end else begin
        tick_d[i] = '0;
      end
      lvl_chg[i]     = (level_d[i] != level_q[i]);
      // Compare next-state values so the flag lines up with the level and
      // target registers of the same cycle.
      at_target_d[i] = (level_d[i] == target_d[i]);
    end
  end

  // A change in the same cycle as the issue re-arms the flag, so the newest
  // level always gets another lookup.
  assign pending_d = (pending_q & ~pend_clr) | lvl_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        level_q[i]  <= '0;
        target_q[i] <= '0;
        rate_q[i]   <= '0;
        tick_q[i]   <= '0;
      end
      pending_q <= '0;
      at_target <= '1;
      cmd_ready <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        level_q[i]  <= level_d[i];
        target_q[i] <= target_d[i];
        rate_q[i]   <= rate_d[i];
        tick_q[i]   <= tick_d[i];
      end
      pending_q <= pending_d;
      at_target <= at_target_d;
      cmd_ready <= 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Lookup scheduler: issue -> wait for ROM -> capture, one lookup per
  // three clocks.
  // ------------------------------------------------------------------------
  gamma_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_clr = '0;
    if (issue) begin
      pend_clr[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lut_addr <= '0;
      cur_ch_q <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (issue) begin
        lut_addr <= level_q[gnt];
        cur_ch_q <= gnt;
      end
      if (capture) begin
        shadow_q[cur_ch_q] <= lut_data;
        rr_ptr_q <= (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // PWM. Active compares only load at counter wrap, so a shadow update can
  // never cut or stretch the pulse already in progress.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_out   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_q + G_OW'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (&pwm_cnt_q) begin
          active_q[i] <= shadow_q[i];
        end
        pwm_out[i] <= (pwm_cnt_q < active_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_gamma_fade_sched.sv
// ---------------------------------------------------------------------------
// tb_gamma_fade_sched
// Self-checking bench for gamma_fade_sched. The DUT is built with a 5-bit
// level and 10-bit compare so a PWM period is 1024 clocks; the ROM model
// returns {addr, addr} (= addr * 33) one clock after the address.
// The level model is closed-form: after a command accepted on edge E from
// level S toward T at rate R, the level k edges later is
// S +/- min(|T-S|, k/R) (or T for k >= 1 when R = 0).
// ---------------------------------------------------------------------------
module tb_gamma_fade_sched;
  import gamma_pkg::*;

  localparam int NC  = 3;
  localparam int PW  = 5;
  localparam int OW  = 10;
  localparam int RW  = 18;
  localparam int PER = 1 << OW;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_ch;
  logic [PW-1:0]     cmd_target;
  logic [RW-1:0]     cmd_rate;
  logic [PW-1:0]     lut_addr;
  logic [OW-1:0]     lut_data;
  logic [NC-1:0]     at_target;
  logic [NC-1:0]     pwm_out;
  sched_state_e      sched_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // level model, one record per channel
  int m_cyc [NC];
  int m_s   [NC];
  int m_t   [NC];
  int m_r   [NC];

  int hi_cnt [NC];

  logic [PW-1:0] exp_q[$];
  int            lut_vals[$];
  int            lut_times[$];
  logic [PW-1:0] lut_prev = '0;

  gamma_fade_sched #(
    .N_CH   (NC),
    .G_PW   (PW),
    .G_OW   (OW),
    .RATE_W (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_target  (cmd_target),
    .cmd_rate    (cmd_rate),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .at_target   (at_target),
    .pwm_out     (pwm_out),
    .sched_state (sched_state)
  );

  // ---- clock / ROM model ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) lut_data <= {lut_addr, lut_addr};

  // ---- checking ----
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- reference model ----
  function automatic int level_at(int ch, int c);
    int k, d, steps;
    k = c - m_cyc[ch];
    if (k <= 0) return m_s[ch];
    if (m_r[ch] == 0) return m_t[ch];
    d = (m_t[ch] > m_s[ch]) ? m_t[ch] - m_s[ch] : m_s[ch] - m_t[ch];
    steps = k / m_r[ch];
    if (steps >= d) return m_t[ch];
    return (m_t[ch] > m_s[ch]) ? m_s[ch] + steps : m_s[ch] - steps;
  endfunction

  function automatic int gamma_of(int lvl);
    return lvl * (1 << PW) + lvl;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NC; ch++) begin
      m_cyc[ch] = cyc;
      m_s[ch]   = 0;
      m_t[ch]   = 0;
      m_r[ch]   = 0;
    end
  endtask

  // Called at a falling edge; the command is accepted on the next rising
  // edge, and the level does not move on that edge.
  task automatic model_cmd(input int ch, input int t, input int r);
    int s;
    if (ch < NC) begin
      s         = level_at(ch, cyc);
      m_s[ch]   = s;
      m_t[ch]   = t;
      m_r[ch]   = r;
      m_cyc[ch] = cyc + 1;
    end
  endtask

  // ---- continuous monitor: at_target every cycle, lut_addr changes ----
  always begin
    @(posedge clk);
    cyc++;
    #2;
    if (rst_n && chk_en) begin
      for (int ch = 0; ch < NC; ch++) begin
        check($sformatf("at_target%0d", ch), int'(at_target[ch]),
              int'(level_at(ch, cyc) == m_t[ch]));
      end
    end
    if (lut_addr != lut_prev) begin
      lut_vals.push_back(int'(lut_addr));
      lut_times.push_back(cyc);
      lut_prev = lut_addr;
    end
  end

  // ---- driver tasks (all entered at a falling edge) ----
  task automatic start_cmd(input int ch, input int t, input int r);
    check("cmd_ready", int'(cmd_ready), 1);
    model_cmd(ch, t, r);
    cmd_valid  = 1'b1;
    cmd_ch     = 2'(ch);
    cmd_target = PW'(t);
    cmd_rate   = RW'(r);
  endtask

  task automatic send_cmd(input int ch, input int t, input int r);
    start_cmd(ch, t, r);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic measure(input int n);
    for (int ch = 0; ch < NC; ch++) hi_cnt[ch] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int ch = 0; ch < NC; ch++) if (pwm_out[ch]) hi_cnt[ch]++;
    end
  endtask

  task automatic wait_settle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      done = 1'b1;
      for (int ch = 0; ch < NC; ch++) if (level_at(ch, cyc) != m_t[ch]) done = 1'b0;
      if (!done) @(negedge clk);
    end
    check("settle_in_time", int'(done), 1);
  endtask

  // Settle, let a wrap pick up the final shadows, then count one period.
  task automatic check_duties(input string tag);
    wait_settle();
    repeat (PER + 40) @(negedge clk);
    measure(PER);
    for (int ch = 0; ch < NC; ch++) begin
      check($sformatf("%s_duty%0d", tag, ch), hi_cnt[ch], gamma_of(m_t[ch]));
    end
  endtask

  task automatic wait_rise(input int ch);
    bit prev, seen;
    prev = pwm_out[ch];
    seen = 1'b0;
    for (int i = 0; i < PER + 100 && !seen; i++) begin
      @(negedge clk);
      if (!prev && pwm_out[ch]) seen = 1'b1;
      prev = pwm_out[ch];
    end
    check("pwm_rise_seen", int'(seen), 1);
  endtask

  // ---- test sequence ----
  initial begin
    int e;
    int len;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ch     = '0;
    cmd_target = '0;
    cmd_rate   = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_lut_addr", int'(lut_addr), 0);
    check("rst_at_target", int'(at_target), 7);
    check("rst_pwm", int'(pwm_out), 0);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    check("rel_cmd_ready_0", int'(cmd_ready), 0);
    @(negedge clk);
    check("rel_cmd_ready_1", int'(cmd_ready), 1);
    measure(2 * PER);
    for (int ch = 0; ch < NC; ch++) check($sformatf("idle_pwm%0d", ch), hi_cnt[ch], 0);
    check("idle_lut_addr", int'(lut_addr), 0);

    // Slow fade on ch0: 16 steps at rate 4 complete 64 clocks after accept
    send_cmd(0, 16, 4);
    e = cyc;
    check("fade_at_tgt_fall", int'(at_target[0]), 0);
    repeat (63) @(negedge clk);
    check("fade_cyc63", int'(at_target[0]), 0);
    @(negedge clk);
    check("fade_cyc64", int'(at_target[0]), 1);
    check("fade_cyc64_time", cyc - e, 64);
    check_duties("fade");

    // Back-to-back jumps: lookups in channel order at 3-clock spacing
    lut_vals.delete();
    lut_times.delete();
    exp_q.delete();
    exp_q.push_back(PW'(10));
    exp_q.push_back(PW'(20));
    exp_q.push_back(PW'(30));
    start_cmd(0, 10, 0);
    @(negedge clk);
    start_cmd(1, 20, 0);
    @(negedge clk);
    start_cmd(2, 30, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    e = cyc - 2;
    repeat (15) @(negedge clk);
    check("rr_lookups", lut_vals.size(), exp_q.size());
    for (int i = 0; i < 3; i++) begin
      logic [PW-1:0] exp_a;
      exp_a = exp_q.pop_front();
      check($sformatf("rr_addr%0d", i), (i < lut_vals.size()) ? lut_vals[i] : -1, int'(exp_a));
      check($sformatf("rr_time%0d", i), (i < lut_times.size()) ? lut_times[i] - e : -1, 2 + 3 * i);
    end
    send_cmd(0, 31, 0);
    send_cmd(1, 31, 0);
    send_cmd(2, 31, 0);
    check_duties("full");

    // Jump command in the middle of a rate-1 fade
    send_cmd(1, 0, 0);
    repeat (10) @(negedge clk);
    send_cmd(1, 31, 1);
    repeat (9) @(negedge clk);
    send_cmd(1, 0, 0);
    check("midfade_at_tgt0", int'(at_target[1]), 0);
    @(negedge clk);
    check("midfade_at_tgt1", int'(at_target[1]), 1);
    check_duties("midfade");

    // Random command bursts, invalid channel index included
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(3, 8);
      for (int j = 0; j < n; j++) begin
        send_cmd($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 6));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check_duties($sformatf("rand%0d", r));
    end

    // Shadow change mid-pulse: current pulse keeps its length
    send_cmd(0, 16, 0);
    check_duties("pre_glitch");
    wait_rise(0);
    len = 1;
    for (int i = 0; i < PER + 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!pwm_out[0]) break;
      len++;
      if (len == 100) start_cmd(0, 8, 0);
    end
    check("pulse_before", len, gamma_of(16));
    wait_rise(0);
    len = 1;
    for (int i = 0; i < PER + 10; i++) begin
      @(negedge clk);
      if (!pwm_out[0]) break;
      len++;
    end
    check("pulse_after", len, gamma_of(8));

    // Reset while the scheduler waits on the ROM
    send_cmd(2, 5, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("in_wait", int'(sched_state), int'(S_WAIT));
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_lut_addr", int'(lut_addr), 0);
    check("arst_pwm", int'(pwm_out), 0);
    check("arst_at_target", int'(at_target), 7);
    check("arst_cmd_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    measure(2 * PER + 10);
    for (int ch = 0; ch < NC; ch++) check($sformatf("post_rst_pwm%0d", ch), hi_cnt[ch], 0);
    check("post_rst_lut_addr", int'(lut_addr), 0);
    check("post_rst_at_target", int'(at_target), 7);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gamma_fade_sched.md
# gamma_fade_sched

Multi-channel fade scheduler and PWM generator for the gamma-corrected LED path. It holds a per-channel brightness level that steps toward a commanded target at a programmable rate. One shared gamma lookup ROM is time-shared between channels through a round-robin scheduler. Each resulting 16-bit compare value drives a glitch-free per-channel PWM output, updated only at PWM period wrap. It sits between the host or sequencer command logic and the LED pins; the gamma ROM is external to this block.

## Interface
- `N_CH`, 3: number of PWM channels (1..4).
- `G_PW`, 8: level and LUT address width.
- `G_OW`, 16: LUT data, compare and PWM counter width.
- `RATE_W`, 18: step-period field width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accept; transfer when `cmd_valid && cmd_ready`.
- `cmd_ch`  in  2  target channel index.
- `cmd_target`  in  G_PW  final level.
- `cmd_rate`  in  RATE_W  clocks per level step; 0 means jump.
- `lut_addr`  out  G_PW  registered gamma ROM address.
- `lut_data`  in  G_OW  ROM data, valid exactly one clock after `lut_addr` changes (synchronous ROM).
- `at_target`  out  N_CH  per-channel flag: level equals target.
- `pwm_out`  out  N_CH  registered active-high PWM.

## Operation
- Reset values:
  - `cmd_ready`=0 during reset, 1 from the first clock after release.
  - `lut_addr`=0, `pwm_out`=0, `at_target`=all 1s.
  - All levels, targets, rates, tick counters, shadow/active compares and the PWM counter = 0; pending flags = 0; round-robin pointer = 0; FSM = IDLE.
- Command:
  - On accept, channel `cmd_ch` loads target and rate and clears its tick counter; no level step that cycle.
  - `cmd_ch >= N_CH` is accepted and discarded.
  - `cmd_ready` stays 1 after reset; back-to-back commands are legal.
- Fade engine, per channel, each clock:
  - If level != target: with rate=0, level := target in the next cycle. Otherwise the tick counter increments; at rate-1 it clears and level moves ±1 toward target.
  - Every level change sets the channel's pending flag.
  - If level == target, the tick counter holds at 0.
  - `at_target` is registered and reflects the level/target state of the current cycle.
- Lookup scheduler FSM:
  - IDLE: if any pending flag is set, pick the first pending channel at or after the RR pointer. Register `lut_addr` := level[ch], clear pending[ch], latch ch, go to WAIT.
  - WAIT: go to CAPT.
  - CAPT: shadow[ch] := `lut_data`; RR pointer := ch+1 mod N_CH; go to IDLE.
  - One lookup every 3 clocks. A level change during WAIT/CAPT re-sets pending, so the latest level is always eventually looked up.
- PWM:
  - Free-running G_OW-bit counter.
  - When counter == all-ones, active[ch] := shadow[ch] for all channels; this is the only update point.
  - `pwm_out[ch]` := (counter < active[ch]). Compare 0 gives constant low; all-ones gives 65535/65536 duty.

## Timing
- `cmd_valid` handshake to first level step: `rate` clocks. Jump (rate=0): level updates 1 clock after accept.
- Level change to shadow update: 3 clocks minimum (pending→IDLE issue→WAIT→CAPT). Worst case is 3·N_CH clocks when all channels are pending.
- Shadow to `pwm_out` effect: up to 2^G_OW clocks (next wrap) + 1 register stage.
- Command and tick for the same channel in the same cycle: the command wins and no step occurs.
- `rst_n` asserted mid-lookup or mid-period: everything returns to reset values immediately; the in-flight lookup is dropped.

## Structure
- Shared package `gamma_pkg`: `G_PW`, `G_OW`, `N_CH` defaults, FSM state enum (IDLE/WAIT/CAPT), channel-index width constant.
- Sub-module `gamma_rr_arbiter`: combinational round-robin pick over the pending vector with a pointer input, plus a grant-valid output.
- The gamma ROM stays outside the block and is shared with the existing `$readmemh` table.

## Test plan
Bench ROM model returns data = {addr, addr} (addr·257) one clock after the address.
- Reset release with no commands → `pwm_out`=0 for 2 full periods, `lut_addr`=0, `at_target`=3'b111, `cmd_ready`=1 from the first clock after release.
- ch0 target 0x10, rate 4 → `at_target[0]` falls; level hits 0x10 at 64 clocks after accept; the first wrap after the final lookup gives active[0]=0x1010, so `pwm_out[0]` is high 4112 clocks per period.
- Commands to ch0/ch1/ch2 in consecutive cycles, all rate 0, target 0xFF → lookups issue in order ch0, ch1, ch2 at 3-clock spacing; all shadows equal 0xFFFF.
- ch1 fading up at rate 1, then a command mid-fade with target 0x00, rate 0 → level reaches 0 one clock later; final shadow is 0x0000 and `pwm_out[1]` is constantly low after the next wrap.
- Change a shadow mid-period → `pwm_out` duty changes only after the counter passes 0xFFFF, with no truncated pulse.
- Assert `rst_n` during WAIT → all outputs return to reset values asynchronously; after release, no stale shadow capture occurs.
